// File: rtl/gpio_irq_pkg.sv
// rtl/gpio_irq_pkg.sv - register indices and register count for the GPIO/IRQ block
package gpio_irq_pkg;
  localparam logic [2:0] REG_GPI_DATA = 3'd0;
  localparam logic [2:0] REG_GPO_DATA = 3'd1;
  localparam logic [2:0] REG_GPO_SET  = 3'd2;
  localparam logic [2:0] REG_GPO_CLR  = 3'd3;
  localparam logic [2:0] REG_IRQ_EN   = 3'd4;
  localparam logic [2:0] REG_IRQ_RISE = 3'd5;
  localparam logic [2:0] REG_IRQ_FALL = 3'd6;
  localparam logic [2:0] REG_IRQ_STAT = 3'd7;
  localparam int         REG_COUNT    = 8;
endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - per-bit input synchroniser with rise/fall detection
module gpio_sync_edge #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  // prev resets to 0 alongside the chain, so pins already high at release read as a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;
endmodule

// File: rtl/gpio_irq_top.sv
// rtl/gpio_irq_top.sv - APB GPIO block with per-pin edge interrupts
module gpio_irq_top
  import gpio_irq_pkg::*;
#(
  parameter int GPI_W       = 16,
  parameter int GPO_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [2:0]       paddr,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [31:0]      pwdata,
  input  logic [GPI_W-1:0] gpi,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  output logic [GPO_W-1:0] gpo,
  output logic             irq
);
  logic [GPI_W-1:0] gpi_data, rise, fall;
  logic [GPO_W-1:0] gpo_q;
  logic [GPI_W-1:0] en_q, rise_en_q, fall_en_q, stat_q;
  logic [GPI_W-1:0] stat_set, stat_clr;
  logic             irq_q;
  logic             wr;
  logic [31:0]      rd_data;
  logic             unused_pwdata;

  gpio_sync_edge #(.WIDTH(GPI_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (pclk),
    .rst_n(presetn),
    .din  (gpi),
    .dout (gpi_data),
    .rise (rise),
    .fall (fall)
  );

  assign wr            = psel & penable & pwrite;
  assign pready        = psel & penable;
  assign pslverr       = wr & (paddr == REG_GPI_DATA);
  assign unused_pwdata = ^pwdata;

  assign stat_set = (rise & rise_en_q) | (fall & fall_en_q);
  assign stat_clr = (wr && paddr == REG_IRQ_STAT) ? pwdata[GPI_W-1:0] : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      gpo_q     <= '0;
      en_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr) begin
        case (paddr)
          REG_GPO_DATA: gpo_q     <= pwdata[GPO_W-1:0];
          REG_GPO_SET:  gpo_q     <= gpo_q | pwdata[GPO_W-1:0];
          REG_GPO_CLR:  gpo_q     <= gpo_q & ~pwdata[GPO_W-1:0];
          REG_IRQ_EN:   en_q      <= pwdata[GPI_W-1:0];
          REG_IRQ_RISE: rise_en_q <= pwdata[GPI_W-1:0];
          REG_IRQ_FALL: fall_en_q <= pwdata[GPI_W-1:0];
          default: ;
        endcase
      end
      // set is OR-ed after the clear so a coincident new edge survives the W1C
      stat_q <= (stat_q & ~stat_clr) | stat_set;
      irq_q  <= |(stat_q & en_q);
    end
  end

  always_comb begin
    rd_data = '0;
    if (psel) begin
      case (paddr)
        REG_GPI_DATA: rd_data[GPI_W-1:0] = gpi_data;
        REG_GPO_DATA: rd_data[GPO_W-1:0] = gpo_q;
        REG_IRQ_EN:   rd_data[GPI_W-1:0] = en_q;
        REG_IRQ_RISE: rd_data[GPI_W-1:0] = rise_en_q;
        REG_IRQ_FALL: rd_data[GPI_W-1:0] = fall_en_q;
        REG_IRQ_STAT: rd_data[GPI_W-1:0] = stat_q;
        default: ;
      endcase
    end
  end

  assign prdata = rd_data;
  assign gpo    = gpo_q;
  assign irq    = irq_q;
endmodule

// File: tb/tb_gpio_irq_top.sv
// tb/tb_gpio_irq_top.sv - directed self-checking bench for gpio_irq_top
module tb_gpio_irq_top;
  logic        pclk = 1'b0;
  logic        presetn;
  logic [2:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [15:0] gpi;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [15:0] gpo;
  logic        irq;

  int errors = 0;
  int checks = 0;

  gpio_irq_top #(.GPI_W(16), .GPO_W(16), .SYNC_STAGES(2)) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .paddr  (paddr),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .gpi    (gpi),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr),
    .gpo    (gpo),
    .irq    (irq)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [15:0] exp_gpo;
    logic        exp_err;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic [2:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output logic err, output logic rdy);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    rd = prdata; err = pslverr; rdy = pready;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic err, rdy;
    apb_xfer(a, 1'b1, d, rd, err, rdy);
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [31:0] rd);
    logic err, rdy;
    apb_xfer(a, 1'b0, 32'h0, rd, err, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge pclk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err, rdy;

    tbl[0]  = '{3'd1, 1'b1, 32'h0000_00F0, 32'h0, 16'h00F0, 1'b0};
    tbl[1]  = '{3'd2, 1'b1, 32'h0000_0003, 32'h0, 16'h00F3, 1'b0};
    tbl[2]  = '{3'd3, 1'b1, 32'h0000_0010, 32'h0, 16'h00E3, 1'b0};
    tbl[3]  = '{3'd1, 1'b0, 32'h0,         32'h0000_00E3, 16'h00E3, 1'b0};
    tbl[4]  = '{3'd2, 1'b0, 32'h0,         32'h0, 16'h00E3, 1'b0};
    tbl[5]  = '{3'd3, 1'b0, 32'h0,         32'h0, 16'h00E3, 1'b0};
    tbl[6]  = '{3'd4, 1'b1, 32'h0000_1234, 32'h0, 16'h00E3, 1'b0};
    tbl[7]  = '{3'd4, 1'b0, 32'h0,         32'h0000_1234, 16'h00E3, 1'b0};
    tbl[8]  = '{3'd0, 1'b1, 32'h0000_FFFF, 32'h0, 16'h00E3, 1'b1};
    tbl[9]  = '{3'd0, 1'b0, 32'h0,         32'h0, 16'h00E3, 1'b0};
    tbl[10] = '{3'd1, 1'b1, 32'hFFFF_FFFF, 32'h0, 16'hFFFF, 1'b0};
    tbl[11] = '{3'd1, 1'b0, 32'h0,         32'h0000_FFFF, 16'hFFFF, 1'b0};
    tbl[12] = '{3'd1, 1'b1, 32'h0,         32'h0, 16'h0000, 1'b0};
    tbl[13] = '{3'd4, 1'b1, 32'h0,         32'h0, 16'h0000, 1'b0};
    tbl[14] = '{3'd4, 1'b0, 32'h0,         32'h0, 16'h0000, 1'b0};
    tbl[15] = '{3'd5, 1'b1, 32'hFFFF_0001, 32'h0, 16'h0000, 1'b0};
    tbl[16] = '{3'd5, 1'b0, 32'h0,         32'h0000_0001, 16'h0000, 1'b0};

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 3'd0; pwdata = 32'h0; gpi = 16'h0;
    idle(3);
    presetn = 1'b1;

    // reset state of every index
    for (int i = 0; i < 8; i++) begin
      apb_xfer(3'(i), 1'b0, 32'h0, rd, err, rdy);
      check($sformatf("reset_rd_%0d", i), rd, 32'h0);
      check($sformatf("reset_err_%0d", i), {31'h0, err}, 32'h0);
    end
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_gpo", {16'h0, gpo}, 32'h0);

    for (int i = 0; i < 17; i++) begin
      apb_xfer(tbl[i].addr, tbl[i].wr, tbl[i].wdata, rd, err, rdy);
      check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
      check($sformatf("vec%0d_rdy", i), {31'h0, rdy}, 32'h1);
      check($sformatf("vec%0d_gpo", i), {16'h0, gpo}, {16'h0, tbl[i].exp_gpo});
      if (!tbl[i].wr) check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
    end

    // rise on gpi[0]: STAT after 3 edges, irq after 4
    apb_write(3'd4, 32'h1);
    gpi = 16'h0001;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd7;
    for (int k = 1; k <= 4; k++) begin
      @(negedge pclk);
      #1;
      if (k == 2 || k == 3) check($sformatf("rise_stat_k%0d", k), prdata, (k >= 3) ? 32'h1 : 32'h0);
      if (k == 3 || k == 4) check($sformatf("rise_irq_k%0d", k), {31'h0, irq}, (k >= 4) ? 32'h1 : 32'h0);
    end
    psel = 1'b0;
    apb_write(3'd7, 32'h1);
    check("w1c_irq_hold", {31'h0, irq}, 32'h1);
    @(negedge pclk);
    check("w1c_irq_drop", {31'h0, irq}, 32'h0);
    apb_read(3'd7, rd);
    check("w1c_stat", rd, 32'h0);

    // fall on gpi[15] with IRQ_EN off
    apb_write(3'd4, 32'h0);
    gpi = 16'h8001;
    idle(5);
    apb_write(3'd6, 32'h8000);
    gpi = 16'h0001;
    idle(5);
    apb_read(3'd7, rd);
    check("fall_stat", rd, 32'h8000);
    check("fall_irq_masked", {31'h0, irq}, 32'h0);
    apb_write(3'd4, 32'h8000);
    check("fall_irq_lag", {31'h0, irq}, 32'h0);
    @(negedge pclk);
    check("fall_irq_on", {31'h0, irq}, 32'h1);
    apb_write(3'd7, 32'h8000);
    apb_write(3'd4, 32'h0);

    // W1C coinciding with a new rise on bit 0
    gpi = 16'h0000;
    idle(5);
    gpi = 16'h0001;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd7; pwdata = 32'h1;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(3'd7, rd);
    check("set_wins", rd, 32'h1);
    apb_write(3'd7, 32'h1);
    apb_read(3'd7, rd);
    check("w1c_alone", rd, 32'h0);

    // index 0 write leaves GPI_DATA; setup-only cycles change nothing
    apb_xfer(3'd0, 1'b1, 32'h0000_FFFE, rd, err, rdy);
    check("idx0_err", {31'h0, err}, 32'h1);
    apb_read(3'd0, rd);
    check("gpi_data", rd, 32'h0001);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 32'hAAAA;
    #1;
    check("setup_err", {31'h0, pslverr}, 32'h0);
    check("setup_rdy", {31'h0, pready}, 32'h0);
    idle(2);
    psel = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    check("setup_gpo", {16'h0, gpo}, 32'h0);

    // reset during access phase aborts the write
    apb_write(3'd5, 32'h1);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 32'h0055;
    @(negedge pclk);
    penable = 1'b1;
    #1 presetn = 1'b0;
    gpi = 16'hFFFF;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    check("abort_gpo", {16'h0, gpo}, 32'h0);
    idle(6);
    apb_read(3'd7, rd);
    check("post_reset_stat", rd, 32'h0);
    apb_read(3'd5, rd);
    check("post_reset_rise_en", rd, 32'h0);
    apb_read(3'd0, rd);
    check("post_reset_gpi", rd, 32'hFFFF);
    check("post_reset_irq", {31'h0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
